// File: rtl/dbg_pkg.sv
// Shared opcodes, response constants and FSM encoding for the serial debug counter responder.
package dbg_pkg;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_STATUS = 2'b10;
    localparam logic [1:0] OP_INC    = 2'b11;

    localparam logic [7:0] NAK_BYTE = 8'hEE;

    // Echo byte plus up to four counter bytes for a 32-bit counter.
    localparam int MAX_RESP_BYTES = 5;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_LO,
        WAIT_HI
    } state_e;

endpackage

// File: rtl/dbg_event_counter.sv
// One wrapping event counter with a sticky overflow flag; clear beats any increment.
// Latency: count and flag update one cycle after the inputs are sampled.
// Backpressure: none, every input pulse is absorbed in the cycle it arrives.
module dbg_event_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_hw,
    input  logic             inc_sw,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam int SUM_W = CNT_W + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [SUM_W-1:0] sum;

    always_comb begin
        // A hardware and a software increment together add two; the carry marks the wrap.
        sum   = {1'b0, cnt_q} + SUM_W'(inc_hw) + SUM_W'(inc_sw);
        cnt_d = sum[CNT_W-1:0];
        ovf_d = ovf_q | sum[CNT_W];
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/dbg_counter_responder.sv
// Decodes one-byte debug commands and streams 1..5 byte responses to a UART transmitter.
// Latency: rx_valid in cycle N gives tx_start in N+2 when tx_ready is high.
// Backpressure: paced by tx_ready; commands arriving while busy are dropped and flagged.
module dbg_counter_responder
    import dbg_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic [NUM_CH-1:0] evt,
    output logic              busy
);

    localparam int NB = CNT_W / 8;

    state_e                               state_q, state_d;
    logic [MAX_RESP_BYTES-1:0][7:0]       resp_q, resp_d;
    logic [2:0]                           idx_q, idx_d;
    logic [2:0]                           last_q, last_d;
    logic                                 tx_start_q, tx_start_d;
    logic [7:0]                           tx_data_q, tx_data_d;
    logic                                 drop_q, drop_d;

    logic [CNT_W-1:0] cnt [NUM_CH];
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] inc_sw;
    logic [NUM_CH-1:0] clr;
    logic [1:0]        op;
    logic [5:0]        ch;
    logic              ch_ok;
    logic              accept;
    logic [CNT_W-1:0]  snap;
    logic [7:0]        ovf_byte;

    assign op       = rx_data[7:6];
    assign ch       = rx_data[5:0];
    assign ch_ok    = (ch < 6'(NUM_CH));
    assign accept   = rx_valid && (state_q == IDLE);
    assign ovf_byte = 8'(ovf);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign inc_sw[gi] = accept && (op == OP_INC)   && (ch == 6'(gi));
        assign clr[gi]    = accept && (op == OP_CLEAR) && (ch == 6'(gi));

        dbg_event_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc_hw (evt[gi]),
            .inc_sw (inc_sw[gi]),
            .clr    (clr[gi]),
            .cnt    (cnt[gi]),
            .ovf    (ovf[gi])
        );
    end

    always_comb begin
        snap = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == 6'(i)) snap = cnt[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        resp_d     = resp_q;
        idx_d      = idx_q;
        last_d     = last_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        drop_d     = drop_q;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    idx_d     = '0;
                    last_d    = '0;
                    state_d   = SEND;
                    resp_d[0] = rx_data;
                    if (op == OP_STATUS) begin
                        resp_d[0] = ovf_byte;
                        resp_d[1] = {7'b0, drop_q};
                        last_d    = 3'd1;
                        drop_d    = 1'b0;
                    end else if (!ch_ok) begin
                        resp_d[0] = NAK_BYTE;
                    end else if (op == OP_READ) begin
                        // Counter snapshot is the pre-update value, sent MSB first.
                        for (int b = 0; b < NB; b++) begin
                            resp_d[b+1] = snap[CNT_W-1-8*b -: 8];
                        end
                        last_d = 3'(NB);
                    end
                end
            end
            SEND: begin
                if (tx_ready) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = resp_q[idx_q];
                    state_d    = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_ready) state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_ready) begin
                    if (idx_q == last_q) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (rx_valid && (state_q != IDLE)) drop_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            resp_q     <= '0;
            idx_q      <= '0;
            last_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            resp_q     <= resp_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            drop_q     <= drop_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dbg_counter_responder.sv
// Directed bench for dbg_counter_responder: abstract command model, UART ready model, byte scoreboard.
module tb_dbg_counter_responder;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int NB     = CNT_W / 8;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data  = 8'h00;
    logic              tx_ready = 1'b1;
    logic [NUM_CH-1:0] evt      = '0;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              busy;

    dbg_counter_responder #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_ready (tx_ready),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .evt      (evt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model state
    longint       m_cnt [NUM_CH];
    bit           m_ovf [NUM_CH];
    bit           m_drop = 0;
    bit           m_busy = 0;
    byte unsigned exp_q[$];
    byte unsigned log_q[$];
    int           start_cyc_q[$];
    int           rise_cyc_q[$];
    int           n_starts = 0;
    int           u_seen   = 0;
    int           ucnt     = 0;
    bit           hold_low = 0;
    int           idle_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every launched byte must be the next expected one, and only when ready.
    always @(negedge clk) begin
        if (tx_start !== 1'b0) begin
            n_starts++;
            log_q.push_back(tx_data);
            start_cyc_q.push_back(cyc);
            check("tx_ready_at_start", tx_ready, 1);
            check("byte_outstanding", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("tx_data", tx_data, exp_q.pop_front());
        end
    end

    // UART transmitter: drops ready the cycle after it sees start, raises it 4 cycles later.
    always @(posedge clk) begin
        #2;
        if (n_starts != u_seen) begin
            u_seen = n_starts;
            ucnt   = 4;
        end else if (ucnt > 0) begin
            ucnt--;
        end
        if (ucnt == 0 && !hold_low) begin
            if (!tx_ready) rise_cyc_q.push_back(cyc);
            tx_ready = 1'b1;
        end else begin
            tx_ready = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_apply(input logic rv, input logic [7:0] rd, input logic [NUM_CH-1:0] ev);
        longint add [NUM_CH];
        int     op, ch;
        byte unsigned ob;
        for (int i = 0; i < NUM_CH; i++) add[i] = ev[i];
        if (rv) begin
            if (m_busy) begin
                m_drop = 1;
            end else begin
                m_busy = 1;
                op = rd[7:6];
                ch = rd[5:0];
                if (op == 2) begin
                    ob = 0;
                    for (int i = 0; i < NUM_CH; i++) ob = ob | (byte'(m_ovf[i]) << i);
                    exp_q.push_back(ob);
                    exp_q.push_back(byte'(m_drop));
                    m_drop = 0;
                end else if (ch >= NUM_CH) begin
                    exp_q.push_back(8'hEE);
                end else begin
                    exp_q.push_back(rd);
                    if (op == 0) begin
                        for (int b = NB - 1; b >= 0; b--) exp_q.push_back(byte'((m_cnt[ch] >> (8 * b)) & 'hFF));
                    end else if (op == 1) begin
                        m_cnt[ch] = 0;
                        m_ovf[ch] = 0;
                        add[ch]   = 0;
                    end else begin
                        add[ch] = add[ch] + 1;
                    end
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = m_cnt[i] + add[i];
            if (m_cnt[i] >= (longint'(1) << CNT_W)) begin
                m_cnt[i] = m_cnt[i] - (longint'(1) << CNT_W);
                m_ovf[i] = 1;
            end
        end
    endtask

    task automatic cycle(input logic rv, input logic [7:0] rd, input logic [NUM_CH-1:0] ev);
        rx_valid = rv;
        rx_data  = rd;
        evt      = ev;
        model_apply(rv, rd, ev);
        tick();
        rx_valid = 1'b0;
        evt      = '0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy !== 1'b0 || exp_q.size() != 0) && n < 2000);
        idle_cyc = cyc;
        check({name, "_idle_in_time"}, n < 2000, 1);
        m_busy = 0;
        tick();
    endtask

    task automatic cmd(input string name, input logic [7:0] rd);
        cycle(1'b1, rd, '0);
        wait_idle(name);
    endtask

    // Hand-computed literal bytes, packed MSB first.
    task automatic check_bytes(input string name, input int base, input int n, input logic [39:0] exp);
        check({name, "_count"}, log_q.size() - base, n);
        for (int k = 0; k < n; k++) begin
            if (base + k < log_q.size()) check(name, log_q[base+k], exp[8*(n-1-k) +: 8]);
        end
    endtask

    initial begin
        int base, rb, c0, ns, n;
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0;
            m_ovf[i] = 0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();

        // Three evt[1] pulses then READ ch1, with latency and pacing checks
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 8'h00, 4'b0010);
            cycle(1'b0, 8'h00, 4'b0000);
        end
        base = log_q.size();
        rb   = rise_cyc_q.size();
        c0   = cyc;
        cmd("t1_read", 8'h01);
        check_bytes("t1_bytes", base, 3, 40'h01_00_03);
        check("t1_latency", start_cyc_q[base] - c0, 2);
        check("t1_gap", start_cyc_q[base+1] - rise_cyc_q[rb], 2);
        check("t1_rises", rise_cyc_q.size() - rb, 3);
        check("t1_busy_fall", idle_cyc - rise_cyc_q[rb+2], 1);

        // Preload ch0 to 0xFFFF (last step is INC with a coincident evt), then wrap it
        for (int k = 0; k < 65533; k++) cycle(1'b0, 8'h00, 4'b0001);
        cycle(1'b1, 8'hC0, 4'b0001);
        wait_idle("t2_inc");
        base = log_q.size();
        cmd("t2_read_full", 8'h00);
        check_bytes("t2_full", base, 3, 40'h00_FF_FF);
        cycle(1'b0, 8'h00, 4'b0001);
        base = log_q.size();
        cmd("t2_status", 8'h80);
        check_bytes("t2_status", base, 2, 40'h01_00);
        base = log_q.size();
        cmd("t2_clear", 8'h40);
        check_bytes("t2_clear", base, 1, 40'h40);
        base = log_q.size();
        cmd("t2_status2", 8'h80);
        check_bytes("t2_status2", base, 2, 40'h00_00);

        // Invalid channels answer NAK and change nothing
        base = log_q.size();
        cmd("t3_nak_read", 8'h05);
        check_bytes("t3_nak_read", base, 1, 40'hEE);
        cmd("t3_nak_clear", 8'h45);
        cmd("t3_nak_inc", 8'hC7);
        base = log_q.size();
        cmd("t3_read1", 8'h01);
        check_bytes("t3_read1", base, 3, 40'h01_00_03);

        // Command while busy is dropped and reported once by STATUS
        base = log_q.size();
        cycle(1'b1, 8'h01, '0);
        repeat (3) cycle(1'b0, 8'h00, '0);
        cycle(1'b1, 8'hC1, '0);
        wait_idle("t4_busy_read");
        check("t4_no_extra_bytes", log_q.size() - base, 3);
        base = log_q.size();
        cmd("t4_status", 8'h80);
        check_bytes("t4_status", base, 2, 40'h00_01);
        base = log_q.size();
        cmd("t4_status2", 8'h80);
        check_bytes("t4_status2", base, 2, 40'h00_00);
        base = log_q.size();
        cmd("t4_read1", 8'h01);
        check_bytes("t4_read1", base, 3, 40'h01_00_03);

        // tx_ready held low: no launch until it rises, then exactly one byte
        @(negedge clk);
        hold_low = 1;
        tick();
        tick();
        base = log_q.size();
        ns   = n_starts;
        cycle(1'b1, 8'hC2, '0);
        repeat (50) tick();
        check("t5_no_start_while_low", n_starts - ns, 0);
        @(negedge clk);
        hold_low = 0;
        tick();
        wait_idle("t5_inc");
        check_bytes("t5_inc", base, 1, 40'hC2);
        base = log_q.size();
        cmd("t5_read2", 8'h02);
        check_bytes("t5_read2", base, 3, 40'h02_00_01);

        // Coincident events: CLEAR wins over evt, INC plus evt adds two
        cycle(1'b0, 8'h00, 4'b1000);
        cycle(1'b0, 8'h00, 4'b1000);
        cycle(1'b1, 8'h43, 4'b1000);
        wait_idle("t6_clear");
        base = log_q.size();
        cmd("t6_read3", 8'h03);
        check_bytes("t6_read3", base, 3, 40'h03_00_00);
        cycle(1'b1, 8'hC2, 4'b0100);
        wait_idle("t6_inc");
        base = log_q.size();
        cmd("t6_read2", 8'h02);
        check_bytes("t6_read2", base, 3, 40'h02_00_03);

        // Reset in the middle of a READ response aborts it
        ns = n_starts;
        cycle(1'b1, 8'h02, '0);
        n = 0;
        while (n_starts == ns && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t7_first_byte_seen", n_starts - ns, 1);
        tick();
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0;
            m_ovf[i] = 0;
        end
        m_drop = 0;
        m_busy = 0;
        @(negedge clk);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_tx_data", tx_data, 8'h00);
        tick();
        rst = 1'b0;
        ns  = n_starts;
        repeat (40) tick();
        check("t7_no_bytes_after_reset", n_starts - ns, 0);
        for (int c = 0; c < NUM_CH; c++) cmd("t7_read", 8'(c));
        base = log_q.size();
        cmd("t7_read2", 8'h02);
        check_bytes("t7_read2", base, 3, 40'h02_00_00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
